// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor
//   Fetch-stage branch predictor. It holds a PHT of 2-bit saturating counters,
//   indexed either by PC (MODE=0) or by PC XOR global history (MODE=1), and a
//   direct-mapped BTB. Lookup is combinational. Training comes from AGEX
//   resolutions and is registered.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   fe_pc           fetch PC to predict
//   pred_taken      prediction for fe_pc is taken
//   pred_target     predicted next PC (BTB target or fe_pc+4)
//   pred_pht_index  PHT index used for fe_pc; carried down the pipeline
//   upd_valid       a branch or jump resolved this cycle
//   upd_pc          PC of the resolved instruction
//   upd_pht_index   PHT index returned from the pipeline
//   upd_is_cond     1 = conditional branch, 0 = unconditional jump
//   upd_taken       resolved direction
//   upd_target      resolved taken target
//   upd_mispred     AGEX flagged a mispredict
//   stat_total      resolved branches/jumps counted
//   stat_correct    resolutions without mispredict
module gshare_btb_predictor #(
  parameter int DBITS        = 32,
  parameter int PHT_IDX_BITS = 10,
  parameter int HIST_BITS    = 8,
  parameter int BTB_IDX_BITS = 4,
  parameter int MODE         = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        fe_pc,
  output logic                    pred_taken,
  output logic [DBITS-1:0]        pred_target,
  output logic [PHT_IDX_BITS-1:0] pred_pht_index,
  input  logic                    upd_valid,
  input  logic [DBITS-1:0]        upd_pc,
  input  logic [PHT_IDX_BITS-1:0] upd_pht_index,
  input  logic                    upd_is_cond,
  input  logic                    upd_taken,
  input  logic [DBITS-1:0]        upd_target,
  input  logic                    upd_mispred,
  output logic [31:0]             stat_total,
  output logic [31:0]             stat_correct
);

  localparam int PHT_N = 1 << PHT_IDX_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

  logic [1:0]              pht        [PHT_N];
  logic                    btb_valid  [BTB_N];
  logic [TAG_W-1:0]        btb_tag    [BTB_N];
  logic [DBITS-1:0]        btb_target [BTB_N];
  logic                    btb_is_jump[BTB_N];
  logic [HIST_BITS-1:0]    ghr;

  logic [PHT_IDX_BITS-1:0] pc_idx;
  logic [BTB_IDX_BITS-1:0] fe_btb_idx;
  logic [TAG_W-1:0]        fe_tag;
  logic                    btb_hit;
  logic [BTB_IDX_BITS-1:0] upd_btb_idx;
  logic [HIST_BITS-1:0]    ghr_next;

  // Byte-offset bits of the PCs carry no information for prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fe_pc[1:0], upd_pc[1:0]};

  always_comb begin
    pc_idx     = fe_pc[PHT_IDX_BITS+1:2];
    fe_btb_idx = fe_pc[BTB_IDX_BITS+1:2];
    fe_tag     = fe_pc[DBITS-1:BTB_IDX_BITS+2];
    if (MODE != 0) begin
      pred_pht_index = pc_idx ^ PHT_IDX_BITS'(ghr);
    end else begin
      pred_pht_index = pc_idx;
    end
    btb_hit     = btb_valid[fe_btb_idx] && (btb_tag[fe_btb_idx] == fe_tag);
    pred_taken  = btb_hit && (btb_is_jump[fe_btb_idx] || pht[pred_pht_index][1]);
    pred_target = pred_taken ? btb_target[fe_btb_idx] : fe_pc + DBITS'(4);
  end

  always_comb begin
    upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
    // Truncating the concatenation is a left shift that also covers HIST_BITS=1.
    ghr_next    = HIST_BITS'({ghr, upd_taken});
  end

  // State with reset: counters, valid bits, history, statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      for (int unsigned i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
      ghr          <= '0;
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (upd_valid) begin
      if (upd_is_cond) begin
        if (upd_taken && pht[upd_pht_index] != 2'b11) begin
          pht[upd_pht_index] <= pht[upd_pht_index] + 2'b01;
        end else if (!upd_taken && pht[upd_pht_index] != 2'b00) begin
          pht[upd_pht_index] <= pht[upd_pht_index] - 2'b01;
        end
        ghr <= ghr_next;
      end
      if (upd_taken) btb_valid[upd_btb_idx] <= 1'b1;
      stat_total <= stat_total + 32'd1;
      if (!upd_mispred) stat_correct <= stat_correct + 32'd1;
    end
  end

  // BTB payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      btb_tag[upd_btb_idx]     <= upd_pc[DBITS-1:BTB_IDX_BITS+2];
      btb_target[upd_btb_idx]  <= upd_target;
      btb_is_jump[upd_btb_idx] <= !upd_is_cond;
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fe_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [9:0]  upd_pht_index;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;

  logic        tk0, tk1;
  logic [31:0] tg0, tg1;
  logic [9:0]  ix0, ix1;
  logic [31:0] tot0, cor0, tot1, cor1;

  always #5 clk = ~clk;

  gshare_btb_predictor #(.DBITS(32), .PHT_IDX_BITS(10), .HIST_BITS(8),
                         .BTB_IDX_BITS(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .fe_pc(fe_pc),
    .pred_taken(tk0), .pred_target(tg0), .pred_pht_index(ix0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pht_index(upd_pht_index),
    .upd_is_cond(upd_is_cond), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .stat_total(tot0), .stat_correct(cor0));

  gshare_btb_predictor #(.DBITS(32), .PHT_IDX_BITS(10), .HIST_BITS(8),
                         .BTB_IDX_BITS(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .fe_pc(fe_pc),
    .pred_taken(tk1), .pred_target(tg1), .pred_pht_index(ix1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pht_index(upd_pht_index),
    .upd_is_cond(upd_is_cond), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .stat_total(tot1), .stat_correct(cor1));

  // Reference model: plain integer arrays following the architectural rules.
  int          m_pht [1024];
  bit          m_bv  [16];
  int unsigned m_btag[16];
  int unsigned m_btgt[16];
  bit          m_bjmp[16];
  int unsigned m_ghr;
  int unsigned m_total, m_correct;

  typedef struct {
    int unsigned pc;
    int unsigned idx0, idx1, tgt0, tgt1, tot, cor;
    bit          tk0, tk1;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 0;
    m_ghr = 0; m_total = 0; m_correct = 0;
  endfunction

  function automatic void model_predict(input int unsigned pc, input bit gshare,
                                        output int unsigned idx, output bit tk,
                                        output int unsigned tgt);
    int unsigned b;
    bit hit;
    idx = (pc / 4) % 1024;
    if (gshare) idx = idx ^ m_ghr;
    b   = (pc / 4) % 16;
    hit = m_bv[b] && (m_btag[b] == pc / 64);
    tk  = hit && (m_bjmp[b] || m_pht[idx] >= 2);
    tgt = tk ? m_btgt[b] : pc + 4;
  endfunction

  function automatic void model_update(input int unsigned pc, input int unsigned idx,
                                       input bit cond, input bit tk,
                                       input int unsigned tgt, input bit mp);
    int unsigned b;
    if (cond) begin
      if (tk && m_pht[idx] < 3) m_pht[idx]++;
      if (!tk && m_pht[idx] > 0) m_pht[idx]--;
      m_ghr = ((m_ghr * 2) + tk) % 256;
    end
    if (tk) begin
      b = (pc / 4) % 16;
      m_bv[b] = 1; m_btag[b] = pc / 64; m_btgt[b] = tgt; m_bjmp[b] = !cond;
    end
    m_total++;
    if (!mp) m_correct++;
  endfunction

  // One cycle of stimulus; the expected response is queued for the monitor.
  task automatic step(input logic [31:0] pc, input logic rst, input logic uv,
                      input logic [31:0] upc, input logic [9:0] uidx,
                      input logic cond, input logic tk,
                      input logic [31:0] tgt, input logic mp);
    exp_t e;
    @(posedge clk);
    #1;
    fe_pc = pc; reset = rst; upd_valid = uv; upd_pc = upc; upd_pht_index = uidx;
    upd_is_cond = cond; upd_taken = tk; upd_target = tgt; upd_mispred = mp;
    e.pc = pc;
    model_predict(pc, 1'b0, e.idx0, e.tk0, e.tgt0);
    model_predict(pc, 1'b1, e.idx1, e.tk1, e.tgt1);
    e.tot = m_total; e.cor = m_correct;
    sbq.push_back(e);
    if (rst) model_reset();
    else if (uv) model_update(upc, uidx, cond, tk, tgt, mp);
  endtask

  task automatic idle(input logic [31:0] pc);
    step(pc, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic cmp(input string name, input int unsigned pc,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s fe_pc=%h actual=%h required=%h", name, pc, act, req);
    end
  endtask

  // Monitor: outputs are valid mid-cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp("idx_m0",    e.pc, {22'd0, ix0}, e.idx0);
        cmp("taken_m0",  e.pc, {31'd0, tk0}, {31'd0, e.tk0});
        cmp("target_m0", e.pc, tg0, e.tgt0);
        cmp("idx_m1",    e.pc, {22'd0, ix1}, e.idx1);
        cmp("taken_m1",  e.pc, {31'd0, tk1}, {31'd0, e.tk1});
        cmp("target_m1", e.pc, tg1, e.tgt1);
        cmp("total",     e.pc, tot0, e.tot);
        cmp("correct",   e.pc, cor0, e.cor);
        cmp("total_m1",  e.pc, tot1, e.tot);
        cmp("correct_m1",e.pc, cor1, e.cor);
      end
    end
  end

  initial begin
    logic [31:0] pc, upc;
    logic [9:0]  uidx;
    logic        cond, tk;
    reset = 1'b1; fe_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_pht_index = '0;
    upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and first training of 0x100.
    idle(32'h100);
    step(32'h100, 0, 1, 32'h100, 10'h040, 1, 1, 32'h80, 1);
    idle(32'h100);
    // Saturate then drain the counter at 0x040.
    repeat (4) step(32'h100, 0, 1, 32'h100, 10'h040, 1, 1, 32'h80, 0);
    step(32'h100, 0, 1, 32'h100, 10'h040, 1, 0, 32'h0, 0);
    idle(32'h100);
    repeat (2) step(32'h100, 0, 1, 32'h100, 10'h040, 1, 0, 32'h0, 1);
    idle(32'h100);
    // Jump at 0x200 predicts taken regardless of counter.
    step(32'h200, 0, 1, 32'h200, 10'h080, 0, 1, 32'h300, 0);
    idle(32'h200);
    // BTB tag alias and PC wrap at the top of the address space.
    step(32'h100, 0, 1, 32'h100, 10'h040, 1, 1, 32'h80, 0);
    idle(32'h140);
    idle(32'hFFFF_FFFC);
    // Reset with a concurrent update discards everything.
    step(32'h100, 1, 1, 32'h100, 10'h040, 1, 1, 32'h80, 0);
    idle(32'h100);
    idle(32'h200);

    // Random traffic over a small PC pool so the tables hit and alias.
    for (int n = 0; n < 800; n++) begin
      pc  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                         : ($urandom_range(0, 127) << 2);
      upc = $urandom_range(0, 127) << 2;
      cond = ($urandom_range(0, 3) != 0);
      tk   = cond ? $urandom_range(0, 1) : 1'b1;
      uidx = ($urandom_range(0, 1) == 0) ? 10'($urandom)
                                         : 10'(((upc / 4) % 1024) ^ m_ghr);
      step(pc, ($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0),
           upc, uidx, cond, tk, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
    end
    idle(32'h100);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
